// File: rtl/cell_bist_ctrl_if.sv
// ============================================================================
// Module   : cell_bist_ctrl_if
// Brief    : Handshake / data bundle between a BIST host and cell_bist_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cell_bist_ctrl_if #(
    parameter int PAT_W = 4,
    parameter int SIG_W = 16
);
    logic             start;
    logic [PAT_W-1:0] pat;
    logic             y;
    logic [SIG_W-1:0] exp_sig;
    logic             busy;
    logic             done;
    logic             pass;
    logic [SIG_W-1:0] sig;

    // master = host / cell side, slave = the BIST controller
    modport master (
        output start, y, exp_sig,
        input  pat, busy, done, pass, sig
    );

    modport slave (
        input  start, y, exp_sig,
        output pat, busy, done, pass, sig
    );
endinterface

`default_nettype wire

// File: rtl/cell_bist_ctrl.sv
// ============================================================================
// Module   : cell_bist_ctrl
// Brief    : Exhaustive-pattern BIST for one combinational cell with CRC-16
//            (x^16+x^12+x^5+1) signature compaction of the Y output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cell_bist_ctrl #(
    parameter int               PAT_W  = 4,
    parameter int               SIG_W  = 16,
    parameter int               SETTLE = 2,
    parameter logic [SIG_W-1:0] SEED   = 16'h0000
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    cell_bist_ctrl_if.slave    bus
);
    localparam int               CNT_W      = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] c_CNT_LOAD = CNT_W'(SETTLE - 1);
    localparam logic [SIG_W-1:0] c_POLY     = SIG_W'(16'h1021);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_APPLY  = 2'd1;
    localparam logic [1:0] c_SAMPLE = 2'd2;
    localparam logic [1:0] c_DONE   = 2'd3;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [PAT_W-1:0] r_pat;
    logic [SIG_W-1:0] r_sig;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;

    logic             w_fb;
    logic [SIG_W-1:0] w_sig_next;
    logic             w_pat_last;

    always_comb begin
        w_fb       = r_sig[SIG_W-1] ^ bus.y;
        w_sig_next = {r_sig[SIG_W-2:0], 1'b0} ^ (w_fb ? c_POLY : '0);
        w_pat_last = &r_pat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
            r_pat   <= '0;
            r_sig   <= SEED;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE, c_DONE: begin
                    // START only matters between runs; a new run reseeds everything
                    if (bus.start) begin
                        r_state <= c_APPLY;
                        r_cnt   <= c_CNT_LOAD;
                        r_pat   <= '0;
                        r_sig   <= SEED;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_pass  <= 1'b0;
                    end
                end
                c_APPLY: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else begin
                        r_state <= c_SAMPLE;
                    end
                end
                c_SAMPLE: begin
                    r_sig <= w_sig_next;
                    if (!w_pat_last) begin
                        r_pat   <= r_pat + PAT_W'(1);
                        r_cnt   <= c_CNT_LOAD;
                        r_state <= c_APPLY;
                    end else begin
                        // last pattern: PAT stays all-ones and the verdict uses the final signature
                        r_state <= c_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_sig_next == bus.exp_sig);
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign bus.pat  = r_pat;
    assign bus.sig  = r_sig;
    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.pass = r_pass;

endmodule

`default_nettype wire

// File: tb/tb_cell_bist_ctrl.sv
// ============================================================================
// Module   : tb_cell_bist_ctrl
// Brief    : Directed self-checking bench for cell_bist_ctrl (three configs).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cell_bist_ctrl;
    logic clk;
    logic rst_n;
    logic inv1;
    int   total;
    int   bad;

    cell_bist_ctrl_if #(.PAT_W(4), .SIG_W(16)) b0 ();
    cell_bist_ctrl_if #(.PAT_W(1), .SIG_W(16)) b1 ();
    cell_bist_ctrl_if #(.PAT_W(4), .SIG_W(16)) b2 ();

    // cell models: tied-low, buffer/inverter, 2-input NAND on A,B
    assign b0.y = 1'b0;
    assign b1.y = b1.pat[0] ^ inv1;
    assign b2.y = ~(b2.pat[0] & b2.pat[1]);

    cell_bist_ctrl #(.PAT_W(4), .SIG_W(16), .SETTLE(2), .SEED(16'h0000)) u0 (
        .clk(clk), .rst_n(rst_n), .bus(b0)
    );
    cell_bist_ctrl #(.PAT_W(1), .SIG_W(16), .SETTLE(1), .SEED(16'h0000)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(b1)
    );
    cell_bist_ctrl #(.PAT_W(4), .SIG_W(16), .SETTLE(1), .SEED(16'h0000)) u2 (
        .clk(clk), .rst_n(rst_n), .bus(b2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (b0.pat !== 4'h0) begin bad++; $display("FAIL reset_pat: got %h want 0", b0.pat); end
        total++; if (b0.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", b0.busy); end
        total++; if (b0.done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", b0.done); end
        total++; if (b0.pass !== 1'b0) begin bad++; $display("FAIL reset_pass: got %b want 0", b0.pass); end
        total++; if (b0.sig !== 16'h0000) begin bad++; $display("FAIL reset_sig: got %h want 0000", b0.sig); end
        rst_n = 1'b1;
        repeat (3) tick;
        total++; if (b0.busy !== 1'b0) begin bad++; $display("FAIL reset_idle_busy: got %b want 0", b0.busy); end
    endtask

    task automatic test_run_zero;
        int n;
        b0.exp_sig = 16'h0000;
        b0.start   = 1'b1;
        tick;
        b0.start   = 1'b0;
        n = 0;
        while (b0.busy === 1'b1 && n < 200) begin
            total++;
            if (b0.pat !== 4'(n / 3)) begin bad++; $display("FAIL zero_pat[%0d]: got %h want %h", n, b0.pat, 4'(n / 3)); end
            n++;
            tick;
        end
        total++; if (n != 48) begin bad++; $display("FAIL zero_busy_len: got %0d want 48", n); end
        total++; if (b0.done !== 1'b1) begin bad++; $display("FAIL zero_done: got %b want 1", b0.done); end
        total++; if (b0.sig !== 16'h0000) begin bad++; $display("FAIL zero_sig: got %h want 0000", b0.sig); end
        total++; if (b0.pass !== 1'b1) begin bad++; $display("FAIL zero_pass: got %b want 1", b0.pass); end
        total++; if (b0.pat !== 4'hf) begin bad++; $display("FAIL zero_pat_end: got %h want f", b0.pat); end
        repeat (3) tick;
        total++; if (b0.done !== 1'b1 || b0.pat !== 4'hf) begin bad++; $display("FAIL zero_hold: got done=%b pat=%h want 1 f", b0.done, b0.pat); end
    endtask

    task automatic test_bad_exp;
        int n;
        b0.exp_sig = 16'h0001;
        b0.start   = 1'b1;
        tick;
        b0.start   = 1'b0;
        total++; if (b0.done !== 1'b0 || b0.pass !== 1'b0 || b0.busy !== 1'b1) begin
            bad++; $display("FAIL badexp_restart: got done=%b pass=%b busy=%b want 0 0 1", b0.done, b0.pass, b0.busy);
        end
        n = 0;
        while (b0.busy === 1'b1 && n < 200) begin
            n++;
            tick;
        end
        total++; if (n != 48) begin bad++; $display("FAIL badexp_busy_len: got %0d want 48", n); end
        total++; if (b0.done !== 1'b1) begin bad++; $display("FAIL badexp_done: got %b want 1", b0.done); end
        total++; if (b0.sig !== 16'h0000) begin bad++; $display("FAIL badexp_sig: got %h want 0000", b0.sig); end
        total++; if (b0.pass !== 1'b0) begin bad++; $display("FAIL badexp_pass: got %b want 0", b0.pass); end
    endtask

    task automatic test_restart_ignored;
        int n;
        b0.exp_sig = 16'h0000;
        b0.start   = 1'b1;
        tick;
        b0.start   = 1'b0;
        n = 0;
        while (b0.busy === 1'b1 && n < 200) begin
            total++;
            if (b0.pat !== 4'(n / 3)) begin bad++; $display("FAIL ign_pat[%0d]: got %h want %h", n, b0.pat, 4'(n / 3)); end
            b0.start = (n == 20);
            n++;
            tick;
        end
        b0.start = 1'b0;
        total++; if (n != 48) begin bad++; $display("FAIL ign_busy_len: got %0d want 48", n); end
        total++; if (b0.done !== 1'b1 || b0.pass !== 1'b1) begin bad++; $display("FAIL ign_done: got done=%b pass=%b want 1 1", b0.done, b0.pass); end
        // raise START while DONE: next cycle must already be a fresh run
        b0.start = 1'b1;
        tick;
        b0.start = 1'b0;
        total++; if (b0.done !== 1'b0 || b0.busy !== 1'b1) begin bad++; $display("FAIL ign_rerun: got done=%b busy=%b want 0 1", b0.done, b0.busy); end
        total++; if (b0.pat !== 4'h0 || b0.sig !== 16'h0000) begin bad++; $display("FAIL ign_reinit: got pat=%h sig=%h want 0 0000", b0.pat, b0.sig); end
    endtask

    task automatic test_reset_midrun;
        repeat (24) tick;
        total++; if (b0.busy !== 1'b1 || b0.pat !== 4'h8) begin bad++; $display("FAIL mid_pre: got busy=%b pat=%h want 1 8", b0.busy, b0.pat); end
        #3;
        rst_n = 1'b0;
        #1;
        total++; if (b0.pat !== 4'h0) begin bad++; $display("FAIL mid_pat: got %h want 0", b0.pat); end
        total++; if (b0.busy !== 1'b0 || b0.done !== 1'b0 || b0.pass !== 1'b0) begin
            bad++; $display("FAIL mid_flags: got busy=%b done=%b pass=%b want 0 0 0", b0.busy, b0.done, b0.pass);
        end
        total++; if (b0.sig !== 16'h0000) begin bad++; $display("FAIL mid_sig: got %h want 0000", b0.sig); end
        repeat (2) tick;
        rst_n = 1'b1;
        repeat (6) tick;
        total++; if (b0.busy !== 1'b0 || b0.done !== 1'b0 || b0.pat !== 4'h0) begin
            bad++; $display("FAIL mid_idle: got busy=%b done=%b pat=%h want 0 0 0", b0.busy, b0.done, b0.pat);
        end
    endtask

    task automatic test_buffer_inverter;
        int n;
        inv1       = 1'b0;
        b1.exp_sig = 16'h2042;
        b1.start   = 1'b1;
        tick;
        b1.start   = 1'b0;
        n = 0;
        while (b1.busy === 1'b1 && n < 50) begin n++; tick; end
        total++; if (n != 4) begin bad++; $display("FAIL buf_busy_len: got %0d want 4", n); end
        total++; if (b1.sig !== 16'h1021) begin bad++; $display("FAIL buf_sig: got %h want 1021", b1.sig); end
        total++; if (b1.done !== 1'b1 || b1.pass !== 1'b0) begin bad++; $display("FAIL buf_pass: got done=%b pass=%b want 1 0", b1.done, b1.pass); end
        inv1     = 1'b1;
        b1.start = 1'b1;
        tick;
        b1.start = 1'b0;
        n = 0;
        while (b1.busy === 1'b1 && n < 50) begin n++; tick; end
        total++; if (n != 4) begin bad++; $display("FAIL inv_busy_len: got %0d want 4", n); end
        total++; if (b1.sig !== 16'h2042) begin bad++; $display("FAIL inv_sig: got %h want 2042", b1.sig); end
        total++; if (b1.done !== 1'b1 || b1.pass !== 1'b1) begin bad++; $display("FAIL inv_pass: got done=%b pass=%b want 1 1", b1.done, b1.pass); end
    endtask

    task automatic test_back_to_back;
        int n;
        inv1     = 1'b0;
        b1.start = 1'b1;
        tick;
        n = 0;
        while (b1.busy === 1'b1 && n < 50) begin n++; tick; end
        total++; if (n != 4) begin bad++; $display("FAIL b2b_busy_len: got %0d want 4", n); end
        total++; if (b1.done !== 1'b1 || b1.sig !== 16'h1021) begin bad++; $display("FAIL b2b_done: got done=%b sig=%h want 1 1021", b1.done, b1.sig); end
        tick;
        total++; if (b1.done !== 1'b0 || b1.busy !== 1'b1) begin bad++; $display("FAIL b2b_one_cycle: got done=%b busy=%b want 0 1", b1.done, b1.busy); end
        total++; if (b1.sig !== 16'h0000 || b1.pat !== 1'b0) begin bad++; $display("FAIL b2b_reseed: got sig=%h pat=%b want 0000 0", b1.sig, b1.pat); end
        b1.start = 1'b0;
        n = 0;
        while (b1.busy === 1'b1 && n < 50) begin n++; tick; end
        total++; if (n != 4 || b1.sig !== 16'h1021) begin bad++; $display("FAIL b2b_second: got len=%0d sig=%h want 4 1021", n, b1.sig); end
    endtask

    task automatic test_nand;
        int          n;
        logic [15:0] g;
        logic [3:0]  p;
        logic        yv;
        logic        fb;
        g = 16'h0000;
        for (int k = 0; k < 16; k++) begin
            p  = 4'(k);
            yv = ~(p[0] & p[1]);
            fb = g[15] ^ yv;
            g  = {g[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        b2.exp_sig = g;
        b2.start   = 1'b1;
        tick;
        b2.start   = 1'b0;
        n = 0;
        while (b2.busy === 1'b1 && n < 100) begin n++; tick; end
        total++; if (n != 32) begin bad++; $display("FAIL nand_busy_len: got %0d want 32", n); end
        total++; if (b2.sig !== g) begin bad++; $display("FAIL nand_sig: got %h want %h", b2.sig, g); end
        total++; if (b2.done !== 1'b1 || b2.pass !== 1'b1) begin bad++; $display("FAIL nand_pass: got done=%b pass=%b want 1 1", b2.done, b2.pass); end
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        rst_n      = 1'b0;
        inv1       = 1'b0;
        b0.start   = 1'b0;
        b0.exp_sig = 16'h0000;
        b1.start   = 1'b0;
        b1.exp_sig = 16'h0000;
        b2.start   = 1'b0;
        b2.exp_sig = 16'h0000;

        test_reset();
        test_run_zero();
        test_bad_exp();
        test_restart_ignored();
        test_reset_midrun();
        test_buffer_inverter();
        test_back_to_back();
        test_nand();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cell_bist_ctrl.md
# cell_bist_ctrl

Built-in self-test controller for characterising a single combinational library cell (AOI/OAI/NAND/NOR/XOR/MUX class) on silicon. It drives an exhaustive input-pattern sequence into the cell under test and reads the cell's Y output back. Y samples are compacted into a serial CRC-style signature, which is compared against an expected value. It sits beside each cell instance on the characterisation test chip; one controller serves one cell.

## Interface
- PAT_W, 4: number of cell inputs driven; patterns run 0 .. 2^PAT_W-1.
- SIG_W, 16: signature register width; fixed at 16 for the polynomial below.
- SETTLE, 2: cycles each pattern is held before Y is sampled; legal range ≥1.
- SEED, 16'h0000: signature initial value.

- CLK  in  1  rising-edge clock.
- CLRB  in  1  asynchronous, active-low reset.
- START  in  1  level; sampled only in IDLE or DONE state.
- PAT  out  PAT_W  pattern driven to cell inputs; PAT[0] goes to the first cell input (A).
- Y  in  1  cell output under test.
- EXP_SIG  in  SIG_W  expected signature; must be stable while BUSY.
- BUSY  out  1  run in progress.
- DONE  out  1  run complete; result valid.
- PASS  out  1  SIG == EXP_SIG at completion; meaningful only when DONE=1.
- SIG  out  SIG_W  signature register.

## Operation
- All outputs are registered.
- States: IDLE, APPLY, SAMPLE, DONE.
- Reset state (CLRB=0, asynchronous): state=IDLE, PAT=0, BUSY=0, DONE=0, PASS=0, SIG=SEED, settle counter=0.
- IDLE, START=1 -> APPLY. Set PAT=0, SIG=SEED, BUSY=1, settle counter=SETTLE-1.
- APPLY: PAT held.
  - Counter>0: decrement.
  - Counter==0: -> SAMPLE.
- SAMPLE: Y is captured into SIG at the end of this cycle.
  - fb = SIG[15] ^ Y.
  - SIG <= {SIG[14:0],1'b0} ^ (fb ? 16'h1021 : 16'h0000), i.e. x^16+x^12+x^5+1.
  - PAT != all-ones: PAT <= PAT+1, counter <= SETTLE-1, -> APPLY.
  - PAT == all-ones: -> DONE. BUSY <= 0, DONE <= 1, PASS <= (next SIG == EXP_SIG). PAT holds all-ones; it does not wrap.
- DONE: SIG, PASS and PAT hold.
  - START=1 -> APPLY with the same initialisation as from IDLE. DONE and PASS clear at the same edge.
- START is ignored in APPLY and SAMPLE; a run cannot be restarted mid-run except by CLRB.
- PASS compares the full SIG_W bits.

## Timing
- Cycle 0: START sampled high. Cycle 1: BUSY=1, PAT=0.
- Each pattern occupies SETTLE+1 cycles: SETTLE in APPLY plus 1 in SAMPLE.
- Y must be valid in the SAMPLE cycle. It is therefore at least SETTLE cycles after PAT changes.
- BUSY is high for exactly 2^PAT_W × (SETTLE+1) cycles. DONE rises on the cycle BUSY falls, with no gap.
- Defaults: BUSY high for 48 cycles.
- Reset asserted mid-run: outputs go to reset values immediately, without waiting for CLK. On release the controller is in IDLE and requires a new START.
- START held high continuously: runs repeat back-to-back. DONE is high for exactly 1 cycle between runs.

## Test plan
- Defaults; Y tied 0; EXP_SIG=16'h0000; pulse START → BUSY high 48 cycles, PAT steps 0..15 (3 cycles each), then DONE=1, SIG=16'h0000, PASS=1.
- Same stimulus with EXP_SIG=16'h0001 → DONE=1, SIG=16'h0000, PASS=0.
- PAT_W=1, SETTLE=1, Y=PAT[0] (buffer cell) → BUSY high 4 cycles, SIG=16'h1021. With Y=~PAT[0] (inverter) → SIG=16'h2042. With EXP_SIG=16'h2042, the buffer gives PASS=0 and the inverter gives PASS=1.
- Defaults; assert START again at cycle 20 of a run → ignored: BUSY stays high through cycle 48 and PAT sequence is unaltered. Then hold START at DONE → new run starts, DONE=1 for exactly 1 cycle, SIG reseeded to 16'h0000.
- Drive CLRB low at cycle 25 mid-run, between clock edges → PAT=0, BUSY=0, DONE=0, PASS=0, SIG=SEED immediately. After release with START=0, the controller remains idle.
- PAT_W=4, SETTLE=1, Y = NAND of PAT[0] and PAT[1] → SIG after the run equals a bench-computed golden model from the same recurrence, and PASS=1 when EXP_SIG is set to that value.
